// File: rtl/gate_bist_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_bist_pkg : shared types and truth-table constants for gate_bist     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Truth tables are indexed by {a,b}
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  localparam logic [7:0] ERR_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_bist_timer : loadable down-counter with terminal-count flag         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module gate_bist_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  // Holds at zero once expired so tc stays asserted until the next load
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gate_bist : drives a 2-input gate through all vectors and checks y       |
// | Option macro GATE_BIST_HALT_EN: stop the run on the first mismatch       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_PASSES    = 1,
  parameter logic [3:0] EXPECT_TT     = TT_NOR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_PASS   = 8'(NUM_PASSES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [1:0] ab_q, ab_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] err_count_q, err_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       timer_load;
  logic       timer_tc;
  logic       mismatch;
  logic       halt_now;
  logic [7:0] err_upd;
  logic [3:0] fail_upd;

  gate_bist_timer #(.WIDTH(4)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .tc       (timer_tc)
  );

  // Case inequality so an unknown y counts as a failure
  assign mismatch = (y !== EXPECT_TT[vec_q]);
  assign err_upd  = mismatch ? sat_inc(err_count_q) : err_count_q;
  assign fail_upd = fail_vec_q | (mismatch ? (4'b0001 << vec_q) : 4'b0000);

`ifdef GATE_BIST_HALT_EN
  assign halt_now = mismatch;
`else
  assign halt_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    ab_d        = ab_q;
    pass_cnt_d  = pass_cnt_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timer_load  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          vec_d       = 2'd0;
          ab_d        = 2'd0;
          pass_cnt_d  = 8'd0;
          err_count_d = 8'd0;
          fail_vec_d  = 4'd0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timer_load  = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_tc) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        err_count_d = err_upd;
        fail_vec_d  = fail_upd;
        if (halt_now || (vec_q == 2'd3 && pass_cnt_q >= LAST_PASS)) begin
          state_d = DONE;
          ab_d    = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_upd == 8'd0);
        end else if (vec_q != 2'd3) begin
          state_d    = SETTLE;
          vec_d      = vec_q + 2'd1;
          ab_d       = vec_q + 2'd1;
          timer_load = 1'b1;
        end else begin
          state_d    = SETTLE;
          vec_d      = 2'd0;
          ab_d       = 2'd0;
          pass_cnt_d = pass_cnt_q + 8'd1;
          timer_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      ab_q        <= 2'd0;
      pass_cnt_q  <= 8'd0;
      err_count_q <= 8'd0;
      fail_vec_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      ab_q        <= ab_d;
      pass_cnt_q  <= pass_cnt_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gate_bist : scoreboard bench, three gate_bist instances each driving  |
// | a truth-table gate model. Revision 1.0                                   |
// +--------------------------------------------------------------------------+
module tb_gate_bist;
  import gate_bist_pkg::*;

  localparam int NI = 3;
  localparam int SET_P [NI] = '{2, 2, 1};
  localparam int PAS_P [NI] = '{1, 3, 255};
`ifdef GATE_BIST_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  typedef struct {
    int         inst;
    int         busy_len;
    int         err;
    logic [3:0] fvec;
    bit         pass;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] start;
  logic [NI-1:0] a_o, b_o, y_w, busy_o, done_o, pass_o;
  logic [7:0]    err_o  [NI];
  logic [3:0]    fvec_o [NI];
  logic [3:0]    tt_g   [NI];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      // Gate under test: output follows a programmable truth table
      assign y_w[k] = tt_g[k][{a_o[k], b_o[k]}];

      gate_bist #(
        .SETTLE_CYCLES (SET_P[k]),
        .NUM_PASSES    (PAS_P[k]),
        .EXPECT_TT     (TT_NOR)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start[k]),
        .y         (y_w[k]),
        .a         (a_o[k]),
        .b         (b_o[k]),
        .busy      (busy_o[k]),
        .done      (done_o[k]),
        .pass      (pass_o[k]),
        .err_count (err_o[k]),
        .fail_vec  (fvec_o[k])
      );
    end
  endgenerate

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: results follow directly from which truth-table entries differ
  function automatic exp_t model(input int k, input logic [3:0] tt);
    exp_t       e;
    logic [3:0] diff;
    int         nbad;
    int         first;
    int         unit;
    int         total;
    diff  = tt ^ TT_NOR;
    nbad  = 0;
    first = -1;
    unit  = SET_P[k] + 1;
    for (int v = 0; v < 4; v++) begin
      if (diff[v]) begin
        nbad++;
        if (first < 0) first = v;
      end
    end
    e.inst = k;
    if (HALT && first >= 0) begin
      e.busy_len = (first + 1) * unit;
      e.err      = 1;
      e.fvec     = 4'(1 << first);
      e.pass     = 1'b0;
    end else begin
      total      = PAS_P[k] * nbad;
      e.busy_len = 4 * PAS_P[k] * unit;
      e.err      = (total > 255) ? 255 : total;
      e.fvec     = diff;
      e.pass     = (total == 0);
    end
    return e;
  endfunction

  // Monitor: measures busy length and a/b walk, scores each finished run
  int            bcnt    [NI];
  bit            walk_ok [NI];
  logic [NI-1:0] busy_prev = '0;
  logic [NI-1:0] done_prev = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          bcnt[k]    = 0;
          walk_ok[k] = 1'b1;
        end else begin
          if (busy_o[k]) begin
            if (!busy_prev[k]) begin
              bcnt[k]    = 0;
              walk_ok[k] = 1'b1;
            end
            if ({a_o[k], b_o[k]} != 2'((bcnt[k] / (SET_P[k] + 1)) % 4)) walk_ok[k] = 1'b0;
            bcnt[k]++;
          end
          if (done_o[k] && !done_prev[k]) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_done[%0d]", k), k, -1);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("inst[%0d]", k), k, e.inst);
              check($sformatf("busy_len[%0d]", k), bcnt[k], e.busy_len);
              check($sformatf("err_count[%0d]", k), err_o[k], e.err);
              check($sformatf("fail_vec[%0d]", k), fvec_o[k], e.fvec);
              check($sformatf("pass[%0d]", k), pass_o[k], e.pass);
              check($sformatf("ab_walk[%0d]", k), walk_ok[k], 1);
              check($sformatf("ab_idle[%0d]", k), {a_o[k], b_o[k]}, 0);
            end
          end
        end
      end
      busy_prev = busy_o;
      done_prev = done_o;
    end
  end

  task automatic wait_done(input int k);
    int c;
    c = 0;
    while (!done_o[k] && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (!done_o[k]) check($sformatf("done_timeout[%0d]", k), 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input int k, input logic [3:0] tt);
    tt_g[k] = tt;
    exp_q.push_back(model(k, tt));
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    wait_done(k);
  endtask

  initial begin
    int c;
    exp_t e;
    rst_n = 1'b0;
    start = '0;
    for (int k = 0; k < NI; k++) tt_g[k] = TT_NOR;
    #12;
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_outputs[%0d]", k),
            {a_o[k], b_o[k], busy_o[k], done_o[k], pass_o[k], err_o[k], fvec_o[k]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, TT_NOR);
    run(1, 4'b0000);
    run(2, 4'b1111);
    run(0, TT_NAND);
    run(0, TT_XOR);
    repeat (6) run(0, 4'($urandom_range(0, 15)));
    repeat (2) run(1, 4'($urandom));

    // Abort a run during the settle window of vector 2
    tt_g[0]  = TT_NOR;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    c = 0;
    while (!(a_o[0] && !b_o[0]) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!(a_o[0] && !b_o[0])) check("reach_vec2_timeout", 0, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0], err_o[0], fvec_o[0]}, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    run(0, TT_NOR);

    // start held high through a failing run, then a restart from DONE
    tt_g[0] = 4'b1001;
    e = model(0, 4'b1001);
    exp_q.push_back(e);
    start[0] = 1'b1;
    @(negedge clk);
    c = 0;
    while (!done_o[0] && c < 5000) begin
      @(negedge clk);
      c++;
    end
    if (!done_o[0]) check("held_start_timeout", 0, 1);
    start[0] = 1'b0;
    @(negedge clk);
    check("done_holds", done_o[0], 1);
    check("err_holds", err_o[0], e.err);
    tt_g[0] = TT_NOR;
    exp_q.push_back(model(0, TT_NOR));
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("restart_clears_err", err_o[0], 0);
    check("restart_clears_fvec", fvec_o[0], 0);
    check("restart_busy", busy_o[0], 1);
    check("restart_done_low", done_o[0], 0);
    wait_done(0);

    // Output stuck at 0: fails on vector 0 only
    run(0, 4'b0000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
